pcm_tdm_framer: RTL and testbench

PCM_TDM_FRAMER -- requirements
Module: pcm_tdm_framer

---
 rtl/pcm_tdm_pkg.sv | 24 ++
 rtl/pcm_tdm_framer_alaw.sv | 40 ++++
 rtl/pcm_tdm_framer.sv | 151 +++++++++++++++
 tb/tb_pcm_tdm_framer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_tdm_pkg.sv
// Shared definitions for the PCM TDM framer.
//   LIN_W / CODE_W    : linear sample width and compressed codeword width
//   IDLE_CODE         : A-law code for a zero sample, used for reset and idle fill
//   ALAW_XOR          : even-bit inversion applied to every transmitted codeword
//   DEFAULT_FAW       : frame alignment word sent in slot 0
//   ch_width()        : width of a channel index, never below one bit
package pcm_tdm_pkg;

  localparam int LIN_W  = 13;
  localparam int CODE_W = 8;

  localparam logic [CODE_W-1:0] IDLE_CODE   = 8'hD5;
  localparam logic [CODE_W-1:0] ALAW_XOR    = 8'h55;
  localparam logic [CODE_W-1:0] DEFAULT_FAW = 8'h1B;

  typedef logic [LIN_W-1:0]  lin_t;
  typedef logic [CODE_W-1:0] code_t;

  // max(1, clog2(n)): a single channel still needs a one-bit index port.
  function automatic int ch_width(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pcm_tdm_framer_alaw.sv
// G.711 A-law compressor, purely combinational.
//   lin  : 13-bit two's complement linear sample
//   code : 8-bit transmitted codeword (sign/segment/mantissa, even bits inverted)
// Negative full scale (-4096) has no 12-bit magnitude and is clamped to 4095.
module alaw_compress
  import pcm_tdm_pkg::*;
(
  input  lin_t  lin,
  output code_t code
);

  logic [LIN_W-1:0] neg_val;
  logic [11:0]      mag;
  logic [2:0]       seg;
  logic [3:0]       shamt;
  logic [3:0]       mant;

  always_comb begin
    neg_val = -lin;
    if (!lin[LIN_W-1]) begin
      mag = lin[11:0];
    end else if (neg_val[LIN_W-1]) begin
      mag = 12'hFFF;
    end else begin
      mag = neg_val[11:0];
    end

    // Ascending scan so the highest set bit decides the segment.
    seg = 3'd0;
    for (int i = 5; i < 12; i++) begin
      if (mag[i]) seg = 3'(i - 4);
    end

    // Segments 0 and 1 share the same step size, so both take mag[4:1].
    shamt = (seg == 3'd0) ? 4'd1 : {1'b0, seg};
    mant  = 4'(mag >> shamt);
    code  = {~lin[LIN_W-1], seg, mant} ^ ALAW_XOR;
  end

endmodule

// File: rtl/pcm_tdm_framer.sv
// PCM TDM framer: compresses linear samples to A-law on write and
// serialises one frame of (NUM_CH+1) 8-bit slots, slot 0 carrying FAW.
//   sys_clk, reset : single clock, synchronous active-high reset
//   en             : run enable; low parks the framer at "next = slot 0 bit 7"
//   bit_en         : one-cycle bit strobe; each strobe presents one bit
//   wr_en/wr_ch/wr_data : sample write into the holding bank
//   ser_out        : serial bit, MSB first
//   frm_sync       : high while slot 0 bit 7 is presented
//   slot_idx       : slot of the bit currently presented
//   wr_err         : one-cycle pulse after a write to a nonexistent channel
// Build option: define PCM_TDM_IDLE_FILL_EN to transmit IDLE_CODE for any
// channel not rewritten during the previous frame; otherwise the last
// written code repeats.
//
// The write port is a fire-and-forget strobe: there is no ready, every
// wr_en cycle is consumed at that edge and a later write to the same
// channel simply overwrites the holding entry.
module pcm_tdm_framer
  import pcm_tdm_pkg::*;
#(
  parameter int              NUM_CH = 4,
  parameter logic [CODE_W-1:0] FAW  = DEFAULT_FAW,
  localparam int CH_W   = ch_width(NUM_CH),
  localparam int SLOT_W = $clog2(NUM_CH + 1)
)(
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              en,
  input  logic              bit_en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [LIN_W-1:0]  wr_data,
  output logic              ser_out,
  output logic              frm_sync,
  output logic [SLOT_W-1:0] slot_idx,
  output logic              wr_err
);

  code_t             wr_code;
  logic              wr_ok;
  logic              wr_hit;
  logic [2:0]        bit_cnt;   // bit number of the next bit to present
  logic [SLOT_W-1:0] slot_cnt;  // slot of the next bit to present
  logic              frame_start;
  logic              last_slot;
  code_t             cur_byte;
  code_t             holding [NUM_CH];
  code_t             bank    [NUM_CH];

  alaw_compress u_alaw (
    .lin  (wr_data),
    .code (wr_code)
  );

  assign wr_ok       = int'(wr_ch) < NUM_CH;
  assign wr_hit      = wr_en && wr_ok;
  assign last_slot   = (slot_cnt == SLOT_W'(NUM_CH));
  assign frame_start = en && bit_en && (slot_cnt == '0) && (bit_cnt == 3'd7);

  // Byte for the slot about to be presented: FAW in slot 0, else the
  // frame bank entry of channel slot-1.
  always_comb begin
    cur_byte = FAW;
    for (int c = 0; c < NUM_CH; c++) begin
      if (slot_cnt == SLOT_W'(c + 1)) cur_byte = bank[c];
    end
  end

  // Bit/slot counters and the registered serial outputs.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      bit_cnt  <= 3'd7;
      slot_cnt <= '0;
      ser_out  <= 1'b0;
      frm_sync <= 1'b0;
      slot_idx <= '0;
    end else if (!en) begin
      bit_cnt  <= 3'd7;
      slot_cnt <= '0;
      ser_out  <= 1'b0;
      frm_sync <= 1'b0;
      slot_idx <= '0;
    end else if (bit_en) begin
      ser_out  <= cur_byte[bit_cnt];
      frm_sync <= frame_start;
      slot_idx <= slot_cnt;
      if (bit_cnt == 3'd0) begin
        bit_cnt  <= 3'd7;
        slot_cnt <= last_slot ? '0 : slot_cnt + SLOT_W'(1);
      end else begin
        bit_cnt <= bit_cnt - 3'd1;
      end
    end
  end

`ifdef PCM_TDM_IDLE_FILL_EN
  logic [NUM_CH-1:0] fresh;

  // Fresh marks channels written since the last frame start. A write on
  // the frame-start edge itself counts toward the following frame, so the
  // set below must win over the clear.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      fresh <= '0;
    end else begin
      if (frame_start) fresh <= '0;
      if (wr_hit) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (wr_ch == CH_W'(c)) fresh[c] <= 1'b1;
        end
      end
    end
  end
`endif

  // Holding bank takes writes; frame bank snapshots it at frame start.
  // Both read the pre-edge holding value, so a same-edge write lands in
  // holding only and shows up one frame later.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        holding[c] <= IDLE_CODE;
        bank[c]    <= IDLE_CODE;
      end
    end else begin
      if (frame_start) begin
        for (int c = 0; c < NUM_CH; c++) begin
`ifdef PCM_TDM_IDLE_FILL_EN
          bank[c] <= fresh[c] ? holding[c] : IDLE_CODE;
`else
          bank[c] <= holding[c];
`endif
        end
      end
      if (wr_hit) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (wr_ch == CH_W'(c)) holding[c] <= wr_code;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok;
    end
  end

endmodule

// File: tb/tb_pcm_tdm_framer.sv
// Testbench for pcm_tdm_framer. Two instances share clock, reset, en and
// bit_en: dut0 (NUM_CH=4) carries the frame-level scenarios, dut1 (NUM_CH=5,
// 3-bit channel port) can address nonexistent channels 5..7 for wr_err.
// A frame-level model predicts every output each cycle; literal frames and
// codewords pin the model.
module tb_pcm_tdm_framer;

  // ---------------- clock / reset ----------------
  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       en      = 1'b0;
  logic       bit_en  = 1'b0;
  logic       wr_en0  = 1'b0;
  logic       wr_en1  = 1'b0;
  logic [1:0] wr_ch0  = '0;
  logic [2:0] wr_ch1  = '0;
  logic [12:0] wr_data = '0;
  logic       ser_out0, frm_sync0, wr_err0;
  logic       ser_out1, frm_sync1, wr_err1;
  logic [2:0] slot_idx0, slot_idx1;
  bit         be_rand = 1'b0;

  always #5 sys_clk = ~sys_clk;

  pcm_tdm_framer #(.NUM_CH(4)) dut0 (
    .sys_clk(sys_clk), .reset(reset), .en(en), .bit_en(bit_en),
    .wr_en(wr_en0), .wr_ch(wr_ch0), .wr_data(wr_data),
    .ser_out(ser_out0), .frm_sync(frm_sync0), .slot_idx(slot_idx0), .wr_err(wr_err0)
  );

  pcm_tdm_framer #(.NUM_CH(5)) dut1 (
    .sys_clk(sys_clk), .reset(reset), .en(en), .bit_en(bit_en),
    .wr_en(wr_en1), .wr_ch(wr_ch1), .wr_data(wr_data),
    .ser_out(ser_out1), .frm_sync(frm_sync1), .slot_idx(slot_idx1), .wr_err(wr_err1)
  );

  // bit_en: every 4th cycle, or random density in the random phase.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge sys_clk);
      if (be_rand) begin
        bit_en = ($urandom_range(0, 2) == 0);
      end else begin
        ph = (ph + 1) % 4;
        bit_en = (ph == 0);
      end
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout, event not seen within budget at t=%0t", nm, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_alaw(logic signed [12:0] x);
    int v, mag, seg, mant, sgn;
    v   = x;
    sgn = (v >= 0) ? 1 : 0;
    mag = (v >= 0) ? v : -v;
    if (mag > 4095) mag = 4095;
    if (mag < 32) begin
      seg  = 0;
      mant = mag / 2;
    end else begin
      seg = 0;
      while ((32 << seg) <= mag) seg++;
      mant = (mag >> seg) % 16;
    end
    return 8'((sgn * 128) + (seg * 16) + mant) ^ 8'h55;
  endfunction

  // Position = index of the next bit within the frame, 0 = FAW bit 7.
  logic [7:0] m_hold [2][32];
  logic [7:0] m_bank [2][32];
  bit         m_fresh[2][32];
  int         m_pos  [2];
  int         m_slot [2];
  logic       m_ser  [2];
  logic       m_sync [2];
  logic       m_err  [2];
  bit         m_tick;

  task automatic model_step(int k, int n, logic w_en, int w_ch);
    int slot, bn;
    logic [7:0] cur;
    if (reset) begin
      m_pos[k] = 0; m_slot[k] = 0; m_ser[k] = 0; m_sync[k] = 0; m_err[k] = 0;
      for (int c = 0; c < 32; c++) begin
        m_hold[k][c] = 8'hD5; m_bank[k][c] = 8'hD5; m_fresh[k][c] = 0;
      end
      return;
    end
    m_err[k] = w_en && (w_ch >= n);
    if (!en) begin
      m_pos[k] = 0; m_slot[k] = 0; m_ser[k] = 0; m_sync[k] = 0;
    end else if (bit_en) begin
      if (m_pos[k] == 0) begin
        for (int c = 0; c < n; c++) begin
`ifdef PCM_TDM_IDLE_FILL_EN
          m_bank[k][c] = m_fresh[k][c] ? m_hold[k][c] : 8'hD5;
`else
          m_bank[k][c] = m_hold[k][c];
`endif
          m_fresh[k][c] = 0;
        end
      end
      slot = m_pos[k] / 8;
      bn   = 7 - (m_pos[k] % 8);
      cur  = (slot == 0) ? 8'h1B : m_bank[k][slot-1];
      m_ser[k]  = cur[bn];
      m_sync[k] = (m_pos[k] == 0);
      m_slot[k] = slot;
      m_pos[k]  = (m_pos[k] + 1) % ((n + 1) * 8);
    end
    if (w_en && (w_ch < n)) begin
      m_hold[k][w_ch]  = ref_alaw(wr_data);
      m_fresh[k][w_ch] = 1;
    end
  endtask

  always @(posedge sys_clk) begin
    m_tick = en && bit_en && !reset;
    model_step(0, 4, wr_en0, int'(wr_ch0));
    model_step(1, 5, wr_en1, int'(wr_ch1));
  end

  // ---------------- compare process ----------------
  always @(negedge sys_clk) begin
    chk("ser0",  32'(ser_out0),  32'(m_ser[0]));
    chk("sync0", 32'(frm_sync0), 32'(m_sync[0]));
    chk("slot0", 32'(slot_idx0), 32'(m_slot[0]));
    chk("err0",  32'(wr_err0),   32'(m_err[0]));
    chk("ser1",  32'(ser_out1),  32'(m_ser[1]));
    chk("sync1", 32'(frm_sync1), 32'(m_sync[1]));
    chk("slot1", 32'(slot_idx1), 32'(m_slot[1]));
    chk("err1",  32'(wr_err1),   32'(m_err[1]));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic wr0(int ch, logic [12:0] d);
    tick();
    wr_en0 = 1'b1; wr_ch0 = 2'(ch); wr_data = d;
    tick();
    wr_en0 = 1'b0;
  endtask

  logic [7:0] fb [5];

  // Collects one full dut0 frame starting at the next FAW bit 7.
  task automatic capture_frame(string nm);
    int guard, got;
    guard = 0;
    while (!(m_tick && frm_sync0) && guard < 400) begin
      tick();
      guard++;
    end
    if (guard >= 400) begin
      timeout_fail(nm);
      return;
    end
    for (int s = 0; s < 5; s++) fb[s] = '0;
    fb[0][7] = ser_out0;
    got = 1;
    guard = 0;
    while (got < 40 && guard < 400) begin
      tick();
      guard++;
      if (m_tick) begin
        fb[got/8][7 - (got % 8)] = ser_out0;
        got++;
      end
    end
    if (got < 40) timeout_fail(nm);
  endtask

  task automatic check_frame(string nm, logic [39:0] exp);
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("%s_slot%0d", nm, s), 32'(fb[s]), 32'(exp[39 - 8*s -: 8]));
    end
  endtask

  function automatic logic [12:0] rand_sample();
    case ($urandom_range(0, 5))
      0: return 13'h1000;
      1: return 13'h0FFF;
      2: return 13'h0000;
      3: return 13'h1FFF;
      default: return 13'($urandom_range(0, 8191));
    endcase
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int guard;

    // Model pinned to hand-computed A-law codes.
    chk("alaw_zero",    32'(ref_alaw(13'd0)),    32'h0D5);
    chk("alaw_pos_max", 32'(ref_alaw(13'd4095)), 32'h0AA);
    chk("alaw_neg_max", 32'(ref_alaw(13'h1000)), 32'h02A);
    chk("alaw_pos_32",  32'(ref_alaw(13'd32)),   32'h0C5);
    chk("alaw_neg_1",   32'(ref_alaw(13'h1FFF)), 32'h055);
    chk("alaw_pos_100", 32'(ref_alaw(13'd100)),  32'h0FC);
    chk("alaw_neg_100", 32'(ref_alaw(13'h1F9C)), 32'h07C);

    repeat (3) tick();
    chk("rst_ser",  32'(ser_out0),  32'd0);
    chk("rst_sync", 32'(frm_sync0), 32'd0);
    chk("rst_slot", 32'(slot_idx0), 32'd0);
    chk("rst_err",  32'(wr_err0),   32'd0);
    reset = 1'b0;

    // Writes land while en is low; first frame carries them.
    wr0(0, 13'd0);
    wr0(1, 13'd100);
    wr0(2, 13'h1F9C);
    wr0(3, 13'd4095);
    tick();
    en = 1'b1;
    capture_frame("frame_a");
    check_frame("frame_a", {8'h1B, 8'hD5, 8'hFC, 8'h7C, 8'hAA});
    capture_frame("frame_b");
`ifdef PCM_TDM_IDLE_FILL_EN
    check_frame("frame_b", {8'h1B, 8'hD5, 8'hD5, 8'hD5, 8'hD5});
`else
    check_frame("frame_b", {8'h1B, 8'hD5, 8'hFC, 8'h7C, 8'hAA});
`endif

    // Refresh every channel, then write ch2 exactly on the frame-start edge.
    guard = 0;
    while (!(m_tick && frm_sync0) && guard < 400) begin tick(); guard++; end
    if (guard >= 400) timeout_fail("refresh_wait");
    wr0(0, 13'd0);
    wr0(1, 13'd100);
    wr0(2, 13'h1F9C);
    wr0(3, 13'd4095);
    guard = 0;
    tick();
    while (!(en && bit_en && m_pos[0] == 0) && guard < 400) begin tick(); guard++; end
    if (guard >= 400) timeout_fail("edge_wait");
    wr_en0 = 1'b1; wr_ch0 = 2'd2; wr_data = 13'd32;
    tick();
    wr_en0 = 1'b0;
    capture_frame("edge_cur");
    check_frame("edge_cur", {8'h1B, 8'hD5, 8'hFC, 8'h7C, 8'hAA});
    capture_frame("edge_next");
`ifdef PCM_TDM_IDLE_FILL_EN
    check_frame("edge_next", {8'h1B, 8'hD5, 8'hD5, 8'hC5, 8'hD5});
`else
    check_frame("edge_next", {8'h1B, 8'hD5, 8'hFC, 8'hC5, 8'hAA});
`endif

    // Reset pulse while slot 3 bit 4 is on the line.
    guard = 0;
    while (!(m_tick && m_pos[0] == 28) && guard < 400) begin tick(); guard++; end
    if (guard >= 400) timeout_fail("slot3_wait");
    chk("pre_rst_slot", 32'(slot_idx0), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_ser",  32'(ser_out0),  32'd0);
    chk("midrst_sync", 32'(frm_sync0), 32'd0);
    chk("midrst_slot", 32'(slot_idx0), 32'd0);
    capture_frame("post_rst");
    check_frame("post_rst", {8'h1B, 8'hD5, 8'hD5, 8'hD5, 8'hD5});

    // Out-of-range write on the five-channel instance.
    tick();
    wr_en1 = 1'b1; wr_ch1 = 3'd5; wr_data = 13'd100;
    tick();
    wr_en1 = 1'b0;
    chk("wr_err_pulse", 32'(wr_err1), 32'd1);
    tick();
    chk("wr_err_clear", 32'(wr_err1), 32'd0);

    // Random phase: writes, enable toggles, rare resets, two bit_en styles.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (i == 1500) be_rand = 1'b1;
      wr_en0  = ($urandom_range(0, 2) == 0);
      wr_ch0  = 2'($urandom_range(0, 3));
      wr_en1  = ($urandom_range(0, 2) == 0);
      wr_ch1  = 3'($urandom_range(0, 7));
      wr_data = rand_sample();
      if ($urandom_range(0, 79) == 0) en = ~en;
      reset = ($urandom_range(0, 399) == 0);
    end
    tick();
    wr_en0 = 1'b0; wr_en1 = 1'b0; reset = 1'b0; en = 1'b1;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
